// File: rtl/fetch_prefetch_queue.sv
// Sequential rv32i instruction fetch with a DEPTH-entry in-order prefetch queue and redirect flush.
// Optional feature macro FETCH_MISALIGN_FAULT_EN: a misaligned redirect/reset PC yields one fault entry and halts fetch.
module fetch_prefetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_fault
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] redir_pc;
    logic            redir_misal;

`ifdef FETCH_MISALIGN_FAULT_EN
    localparam logic [XLEN-1:0] RESET_PC_EFF = RESET_PC;
    localparam logic            RESET_MISAL  = |RESET_PC[1:0];
    assign redir_pc    = redirect_pc;
    assign redir_misal = |redirect_pc[1:0];
`else
    localparam logic [XLEN-1:0] RESET_PC_EFF = {RESET_PC[XLEN-1:2], 2'b00};
    localparam logic            RESET_MISAL  = 1'b0;
    assign redir_pc    = redirect_pc & ~XLEN'(3);
    assign redir_misal = 1'b0;
`endif

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d, outst_q, outst_d, discard_q, discard_d;
    logic            halted_q, halted_d;

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];
    logic            fault_mem[DEPTH];

    logic            req_fire, pop, push, push_fault;
    logic [PW-1:0]   push_idx;
    logic [XLEN-1:0] push_pc, push_data;
    logic [CW:0]     inflight;

    // Credit covers queued entries, live requests and responses still owed to a past redirect.
    assign inflight      = (CW+1)'(count_q) + (CW+1)'(outst_q) + (CW+1)'(discard_q);
    assign mem_req_valid = ~reset & enable & ~redirect_valid & ~halted_q
                         & (inflight < (CW+1)'(DEPTH));
    assign mem_req_addr  = fetch_pc_q;
    assign req_fire      = mem_req_valid & mem_req_ready;

    assign instr_valid = (count_q != '0);
    assign instr_pc    = instr_valid ? pc_mem[head_q]    : '0;
    assign instr_data  = instr_valid ? data_mem[head_q]  : '0;
    assign instr_fault = instr_valid ? fault_mem[head_q] : 1'b0;
    assign pop         = instr_valid & instr_ready & ~redirect_valid;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        halted_d   = halted_q;
        push       = 1'b0;
        push_idx   = tail_q;
        push_pc    = rsp_pc_q;
        push_data  = mem_rsp_data;
        push_fault = 1'b0;
        if (redirect_valid) begin
            // Everything still in flight becomes stale; a response arriving now is dropped outright.
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            outst_d    = '0;
            discard_d  = outst_q + discard_q - CW'(mem_rsp_valid);
            fetch_pc_d = redir_pc;
            rsp_pc_d   = redir_pc;
            halted_d   = 1'b0;
            if (redir_misal) begin
                push       = 1'b1;
                push_idx   = '0;
                push_pc    = redir_pc;
                push_data  = '0;
                push_fault = 1'b1;
                tail_d     = PW'(1);
                count_d    = CW'(1);
                halted_d   = 1'b1;
            end
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (mem_rsp_valid) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    push     = 1'b1;
                    rsp_pc_d = rsp_pc_q + XLEN'(4);
                    tail_d   = tail_q + PW'(1);
                end
            end
            outst_d = outst_q + CW'(req_fire) - CW'(mem_rsp_valid && (discard_q == '0));
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC_EFF;
            rsp_pc_q   <= RESET_PC_EFF;
            head_q     <= '0;
            tail_q     <= PW'(RESET_MISAL);
            count_q    <= CW'(RESET_MISAL);
            outst_q    <= '0;
            discard_q  <= '0;
            halted_q   <= RESET_MISAL;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            halted_q   <= halted_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            if (RESET_MISAL) begin
                pc_mem[0]    <= RESET_PC_EFF;
                data_mem[0]  <= '0;
                fault_mem[0] <= 1'b1;
            end
        end else if (push) begin
            pc_mem[push_idx]    <= push_pc;
            data_mem[push_idx]  <= push_data;
            fault_mem[push_idx] <= push_fault;
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        (push && !redirect_valid) |-> (count_q < CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: in-order 1-cycle memory model with hold control and a delivery log.
module tb_fetch_prefetch_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clock;
    logic            reset, enable, redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            mem_req_valid, mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;
    logic            instr_valid, instr_ready, instr_fault;
    logic [XLEN-1:0] instr_data, instr_pc;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } item_t;

    int          total = 0;
    int          bad   = 0;
    int          req_cnt;
    bit          mem_en;
    logic [31:0] pend[$];
    item_t       got[$];

    fetch_prefetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc), .instr_fault(instr_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // One clock: memory answers oldest pending request (if enabled), log handshakes, advance to next negedge.
    task automatic cycle();
        bit          fire, popf, rspf;
        logic [31:0] addr;
        item_t       it;
        rspf          = mem_en && (pend.size() > 0);
        mem_rsp_valid = rspf;
        mem_rsp_data  = rspf ? mem_word(pend[0]) : 32'h0;
        #1;
        fire = mem_req_valid && mem_req_ready;
        addr = mem_req_addr;
        popf = instr_valid && instr_ready && !redirect_valid;
        if (popf) begin
            it.pc = instr_pc; it.data = instr_data; it.fault = instr_fault;
            got.push_back(it);
        end
        @(posedge clock);
        if (rspf) void'(pend.pop_front());
        if (fire) begin
            pend.push_back(addr);
            req_cnt++;
        end
        @(negedge clock);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_reset();
        reset = 1; enable = 0; redirect_valid = 0; redirect_pc = 0;
        mem_req_ready = 1; instr_ready = 0; mem_en = 1;
        run(2);
        pend.delete(); got.delete(); req_cnt = 0;
        reset = 0;
    endtask

    task automatic check_seq(input string name, input logic [31:0] base, input int n);
        total++;
        if (got.size() < n) begin
            bad++;
            $display("FAIL %s_count got=%0d need>=%0d", name, got.size(), n);
        end
        for (int i = 0; i < n && i < got.size(); i++) begin
            total++;
            if (got[i].pc !== base + 32'(4*i) || got[i].data !== mem_word(base + 32'(4*i)) || got[i].fault !== 1'b0) begin
                bad++;
                $display("FAIL %s[%0d] got pc=%h data=%h fault=%b exp pc=%h data=%h fault=0",
                         name, i, got[i].pc, got[i].data, got[i].fault, base + 32'(4*i), mem_word(base + 32'(4*i)));
            end
        end
    endtask

    task automatic test_reset();
        reset = 1; enable = 1; redirect_valid = 0; redirect_pc = 0;
        mem_req_ready = 1; instr_ready = 1; mem_en = 1;
        run(2);
        total++;
        if (instr_valid !== 1'b0 || instr_fault !== 1'b0) begin
            bad++; $display("FAIL reset_valid got valid=%b fault=%b exp 0 0", instr_valid, instr_fault);
        end
        total++;
        if (instr_data !== 32'h0 || instr_pc !== 32'h0) begin
            bad++; $display("FAIL reset_data got data=%h pc=%h exp 0 0", instr_data, instr_pc);
        end
        total++;
        if (mem_req_valid !== 1'b0) begin
            bad++; $display("FAIL reset_req got=%b exp=0", mem_req_valid);
        end
        pend.delete(); got.delete(); req_cnt = 0;
        reset = 0;
        #1;
        total++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin
            bad++; $display("FAIL first_req got valid=%b addr=%h exp 1 00000000", mem_req_valid, mem_req_addr);
        end
    endtask

    task automatic test_stream();
        do_reset();
        enable = 1; instr_ready = 1;
        cycle();
        total++;
        if (instr_valid !== 1'b0) begin
            bad++; $display("FAIL stream_lat1 got valid=%b exp=0", instr_valid);
        end
        cycle();
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== 32'hA5A5_0000) begin
            bad++; $display("FAIL stream_lat2 got valid=%b pc=%h data=%h exp 1 0 a5a50000", instr_valid, instr_pc, instr_data);
        end
        run(10);
        check_seq("stream", 32'h0, 8);
    endtask

    task automatic test_back_to_back_full();
        do_reset();
        enable = 1; instr_ready = 0;
        run(10);
        total++;
        if (req_cnt !== 4) begin
            bad++; $display("FAIL full_reqs got=%0d exp=4", req_cnt);
        end
        total++;
        if (mem_req_valid !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            bad++; $display("FAIL full_state got req=%b valid=%b pc=%h exp 0 1 0", mem_req_valid, instr_valid, instr_pc);
        end
        instr_ready = 1;
        run(8);
        check_seq("full_drain", 32'h0, 5);
        total++;
        if (req_cnt <= 4) begin
            bad++; $display("FAIL full_resume got=%0d exp>4", req_cnt);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        mem_en = 0; enable = 1; instr_ready = 1;
        run(3);
        enable = 0;
        total++;
        if (req_cnt !== 3) begin
            bad++; $display("FAIL redir_inflight got=%0d exp=3", req_cnt);
        end
        redirect_valid = 1; redirect_pc = 32'h100; enable = 1;
        cycle();
        redirect_valid = 0; mem_en = 1;
        run(14);
        check_seq("redir", 32'h100, 4);
    endtask

    task automatic test_redirect_collide();
        int rc;
        do_reset();
        enable = 1; instr_ready = 0;
        run(3);
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || pend.size() !== 1) begin
            bad++; $display("FAIL coll_pre got valid=%b pc=%h pend=%0d exp 1 0 1", instr_valid, instr_pc, pend.size());
        end
        rc = req_cnt;
        redirect_valid = 1; redirect_pc = 32'h200; instr_ready = 1;
        cycle();
        redirect_valid = 0;
        total++;
        if (instr_valid !== 1'b0 || got.size() !== 0) begin
            bad++; $display("FAIL coll_empty got valid=%b pops=%0d exp 0 0", instr_valid, got.size());
        end
        total++;
        if (req_cnt !== rc) begin
            bad++; $display("FAIL coll_noreq got=%0d exp=%0d", req_cnt, rc);
        end
        run(6);
        check_seq("coll", 32'h200, 2);
    endtask

    task automatic test_enable();
        do_reset();
        mem_en = 0; enable = 1; instr_ready = 1;
        run(2);
        enable = 0; mem_en = 1;
        run(6);
        total++;
        if (req_cnt !== 2 || got.size() !== 2) begin
            bad++; $display("FAIL enable_counts got reqs=%0d pops=%0d exp 2 2", req_cnt, got.size());
        end
        check_seq("enable", 32'h0, 2);
    endtask

    task automatic test_misalign();
        int rc;
        do_reset();
        enable = 1; instr_ready = 0;
        run(2);
        redirect_valid = 1; redirect_pc = 32'h102;
        cycle();
        redirect_valid = 0;
        rc = req_cnt;
        run(6);
`ifdef FETCH_MISALIGN_FAULT_EN
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h102 || instr_fault !== 1'b1 || instr_data !== 32'h0) begin
            bad++; $display("FAIL mis_entry got valid=%b pc=%h fault=%b data=%h exp 1 102 1 0",
                            instr_valid, instr_pc, instr_fault, instr_data);
        end
        total++;
        if (req_cnt !== rc || mem_req_valid !== 1'b0) begin
            bad++; $display("FAIL mis_halt got reqs=%0d req_valid=%b exp %0d 0", req_cnt, mem_req_valid, rc);
        end
`else
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr_fault !== 1'b0 || instr_data !== mem_word(32'h100)) begin
            bad++; $display("FAIL mis_aligned got valid=%b pc=%h fault=%b data=%h exp 1 100 0 %h",
                            instr_valid, instr_pc, instr_fault, instr_data, mem_word(32'h100));
        end
        total++;
        if (req_cnt <= rc) begin
            bad++; $display("FAIL mis_fetch got=%0d exp>%0d", req_cnt, rc);
        end
`endif
        redirect_valid = 1; redirect_pc = 32'h200; instr_ready = 1;
        cycle();
        redirect_valid = 0;
        run(8);
        check_seq("mis_recover", 32'h200, 3);
    endtask

    initial begin
        reset = 1; enable = 0; redirect_valid = 0; redirect_pc = 0;
        mem_req_ready = 1; mem_rsp_valid = 0; mem_rsp_data = 0;
        instr_ready = 0; mem_en = 1; req_cnt = 0;
        @(negedge clock);
        test_reset();
        test_stream();
        test_back_to_back_full();
        test_redirect();
        test_redirect_collide();
        test_enable();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
